// File: rtl/ramb16_s1_bit_reader_if.sv
// ---------------------------------------------------------------------------
// ramb16_s1_bit_reader_if
//
// Bundles every non-clock signal of the bit reader into one interface:
//   start_*   : command channel (valid/ready, first bit address, bit count)
//   ram_*     : port B of the 1-bit x 2^ADDR_BITS block RAM
//   out_*     : packed word stream (valid/ready, data, last flag)
//   busy      : high while a command is in progress
//
// Modports:
//   slave  - the reader engine (drives start_ready, ram_*, out_*, busy)
//   master - the environment (commander, RAM read data, stream consumer)
// ---------------------------------------------------------------------------
interface ramb16_s1_bit_reader_if #(
  parameter int OUT_BITS  = 8,
  parameter int ADDR_BITS = 14
);
  logic                 start_valid;
  logic                 start_ready;
  logic [ADDR_BITS-1:0] start_addr;
  logic [ADDR_BITS:0]   start_len;
  logic [ADDR_BITS-1:0] ram_addr;
  logic                 ram_en;
  logic                 ram_we;
  logic                 ram_ssr;
  logic                 ram_do;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_BITS-1:0]  out_data;
  logic                 out_last;
  logic                 busy;

  modport slave (
    input  start_valid, start_addr, start_len, ram_do, out_ready,
    output start_ready, ram_addr, ram_en, ram_we, ram_ssr,
           out_valid, out_data, out_last, busy
  );

  modport master (
    output start_valid, start_addr, start_len, ram_do, out_ready,
    input  start_ready, ram_addr, ram_en, ram_we, ram_ssr,
           out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/ramb16_s1_bit_reader.sv
// ---------------------------------------------------------------------------
// ramb16_s1_bit_reader
//
// Read-side engine for a 1-bit wide dual-port block RAM. A command gives a
// first bit address and a bit count; the engine walks port B (wrapping at the
// top of the RAM), packs the returned bits LSB-first into OUT_BITS-wide words
// and presents them on a valid/ready stream, flagging the final word.
//
// Ports:
//   CLK      - clock, all logic on the rising edge
//   reset_n  - synchronous active-low reset
//   bus      - ramb16_s1_bit_reader_if.slave (command, RAM port B, stream)
// ---------------------------------------------------------------------------
module ramb16_s1_bit_reader #(
  parameter int OUT_BITS  = 8,
  parameter int ADDR_BITS = 14
) (
  input logic                   CLK,
  input logic                   reset_n,
  ramb16_s1_bit_reader_if.slave bus
);

  localparam int CW = $clog2(OUT_BITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [CW-1:0]      CNT_FULL = CW'(OUT_BITS);
  localparam logic [ADDR_BITS:0] LEN_ONE  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  logic [1:0]           r_state;
  logic [ADDR_BITS-1:0] r_addr;
  logic [ADDR_BITS:0]   r_remaining;   // bits still to be issued
  logic                 r_inflight;    // a read was issued last cycle
  logic [OUT_BITS-1:0]  r_acc;
  logic [CW-1:0]        r_cnt;         // bits held in r_acc
  logic                 r_out_valid;
  logic [OUT_BITS-1:0]  r_out_data;
  logic                 r_out_last;

  logic                 w_out_free;
  logic [CW-1:0]        w_pending;
  logic                 w_stall;
  logic                 w_issue;
  logic [OUT_BITS-1:0]  w_acc_cap;
  logic                 w_final;
  logic                 w_move;

  // Output register can take a new word this cycle.
  assign w_out_free = !r_out_valid || bus.out_ready;

  // Bits already committed to the accumulator (captured + in flight). This is
  // also the accumulator count after this cycle's capture.
  assign w_pending = r_cnt + CW'(r_inflight);

  // Issuing another read would overrun a full accumulator that cannot drain.
  assign w_stall = (w_pending == CNT_FULL) && !w_out_free;

  assign w_issue = (r_state == S_READ) && (r_remaining != '0) && !w_stall;

  // Place the returning bit at position r_cnt; the accumulator is cleared on
  // every move, so bits above the last one captured stay zero.
  assign w_acc_cap = r_inflight ? (r_acc | (OUT_BITS'(bus.ram_do) << r_cnt)) : r_acc;

  // In FLUSH nothing more is issued, so after this edge every bit of the
  // command is in the accumulator or already passed downstream.
  assign w_final = (r_state == S_FLUSH);

  assign w_move = w_out_free &&
                  ((w_pending == CNT_FULL) || (w_final && w_pending != '0));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous and also clears the accumulator and the
    // in-flight flag, so an abandoned command leaves no stale bits behind.
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_valid) begin
            r_addr      <= bus.start_addr;
            r_remaining <= bus.start_len;
            if (bus.start_len != '0) r_state <= S_READ;
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_addr      <= r_addr + ADDR_ONE;   // wraps at the top of the RAM
            r_remaining <= r_remaining - LEN_ONE;
            if (r_remaining == LEN_ONE) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_out_valid && bus.out_ready && r_out_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      r_inflight <= w_issue;

      if (w_move) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_acc_cap;
        r_cnt <= w_pending;
      end

      // A move may coincide with the consumer taking the previous word.
      if (w_move) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_acc_cap;
        r_out_last  <= w_final;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign bus.start_ready = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.ram_addr    = r_addr;
  assign bus.ram_en      = w_issue;
  assign bus.ram_we      = 1'b0;
  assign bus.ram_ssr     = 1'b0;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_last    = r_out_last;

endmodule

// File: tb/tb_ramb16_s1_bit_reader.sv
// ---------------------------------------------------------------------------
// tb_ramb16_s1_bit_reader
//
// Directed bench for ramb16_s1_bit_reader (OUT_BITS=8, ADDR_BITS=14) with a
// behavioural 1-cycle-latency bit RAM on port B.
// ---------------------------------------------------------------------------
module tb_ramb16_s1_bit_reader;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ramb16_s1_bit_reader_if #(.OUT_BITS(8), .ADDR_BITS(14)) bus ();

  ramb16_s1_bit_reader #(.OUT_BITS(8), .ADDR_BITS(14)) dut (
    .CLK     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  logic mem [0:16383];

  always @(posedge clk) begin
    if (bus.ram_en) bus.ram_do <= mem[bus.ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Results collected by run_cmd.
  logic [7:0]  got_data [$];
  logic        got_last [$];
  logic [13:0] en_addrs [$];
  int first_en_cyc, first_valid_cyc, last_valid_cyc, busy_low_cyc;
  int stall_viol, hold_viol, ctl_viol, stall_events;
  logic ready_c1;

  function automatic logic ready_pattern(input int c);
    if (c >= 14 && c <= 40) return 1'b0;
    if (c >= 60 && c <= 75) return 1'b0;
    return ((c % 3) != 0) && ((c % 7) != 5);
  endfunction

  // Issue one command and observe it until busy falls (or max_cyc expires).
  task automatic run_cmd(input logic [13:0] addr, input logic [14:0] len,
                         input bit toggle, input int max_cyc);
    int issued, nloaded, bits_loaded, pending;
    logic prev_hold;
    logic [7:0] prev_data;
    got_data.delete(); got_last.delete(); en_addrs.delete();
    first_en_cyc = -1; first_valid_cyc = -1; last_valid_cyc = -1; busy_low_cyc = -1;
    stall_viol = 0; hold_viol = 0; ctl_viol = 0; stall_events = 0; ready_c1 = 1'b0;
    issued = 0; nloaded = 0; prev_hold = 1'b0; prev_data = '0;
    @(negedge clk);
    bus.start_valid = 1'b1; bus.start_addr = addr; bus.start_len = len; bus.out_ready = 1'b1;
    @(posedge clk);  // accept edge: cycle 0
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
      bus.out_ready = toggle ? ready_pattern(c) : 1'b1;
      #1;
      if (c == 1) ready_c1 = bus.start_ready;
      if (bus.ram_we !== 1'b0 || bus.ram_ssr !== 1'b0) ctl_viol++;
      if (prev_hold && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data)) hold_viol++;
      if (bus.out_valid && !prev_hold) nloaded++;
      bits_loaded = (nloaded * 8 > int'(len)) ? int'(len) : nloaded * 8;
      pending = issued - bits_loaded;
      if (pending == 8 && bus.out_valid && !bus.out_ready) begin
        stall_events++;
        if (bus.ram_en) stall_viol++;
      end
      if (pending > 8 || pending < 0) stall_viol++;
      if (bus.ram_en) begin
        issued++;
        en_addrs.push_back(bus.ram_addr);
        if (first_en_cyc < 0) first_en_cyc = c;
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        if (bus.out_last) last_valid_cyc = c;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (!bus.busy) begin
        busy_low_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    n_tests++; if (bus.start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready: got %b want 1", bus.start_ready); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en: got %b want 0", bus.ram_en); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    n_tests++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    n_tests++; if (bus.ram_addr !== 14'd0) begin n_fail++; $display("FAIL reset_ram_addr: got %0d want 0", bus.ram_addr); end
    n_tests++; if (bus.ram_we !== 1'b0 || bus.ram_ssr !== 1'b0) begin n_fail++; $display("FAIL reset_we_ssr: got %b%b want 00", bus.ram_we, bus.ram_ssr); end
  endtask

  task automatic test_basic;
    logic pat [0:15] = '{1,0,1,1,0,0,0,1,1,1,1,1,0,0,0,0};
    for (int i = 0; i < 16; i++) mem[i] = pat[i];
    run_cmd(14'd0, 15'd16, 1'b0, 60);
    n_tests++; if (busy_low_cyc !== 19) begin n_fail++; $display("FAIL basic_busy_low: got cycle %0d want 19", busy_low_cyc); end
    n_tests++; if (first_en_cyc !== 1) begin n_fail++; $display("FAIL basic_first_en: got cycle %0d want 1", first_en_cyc); end
    n_tests++; if (first_valid_cyc !== 10) begin n_fail++; $display("FAIL basic_first_valid: got cycle %0d want 10", first_valid_cyc); end
    n_tests++; if (last_valid_cyc !== 18) begin n_fail++; $display("FAIL basic_last_valid: got cycle %0d want 18", last_valid_cyc); end
    n_tests++; if (got_data.size() !== 2) begin n_fail++; $display("FAIL basic_word_count: got %0d want 2", got_data.size()); end
    if (got_data.size() == 2) begin
      n_tests++; if (got_data[0] !== 8'h8D || got_last[0] !== 1'b0) begin n_fail++; $display("FAIL basic_word0: got %h/last %b want 8d/last 0", got_data[0], got_last[0]); end
      n_tests++; if (got_data[1] !== 8'h0F || got_last[1] !== 1'b1) begin n_fail++; $display("FAIL basic_word1: got %h/last %b want 0f/last 1", got_data[1], got_last[1]); end
    end
    n_tests++; if (en_addrs.size() !== 16) begin n_fail++; $display("FAIL basic_read_count: got %0d want 16", en_addrs.size()); end
    n_tests++; if (ctl_viol !== 0) begin n_fail++; $display("FAIL basic_we_ssr: got %0d nonzero cycles want 0", ctl_viol); end
  endtask

  task automatic test_wrap;
    logic [13:0] ea;
    for (int i = 16380; i < 16384; i++) mem[i] = 1'b1;
    for (int i = 0; i < 4; i++) mem[i] = 1'b0;
    run_cmd(14'd16380, 15'd8, 1'b0, 40);
    n_tests++; if (en_addrs.size() !== 8) begin n_fail++; $display("FAIL wrap_read_count: got %0d want 8", en_addrs.size()); end
    for (int i = 0; i < 8 && i < en_addrs.size(); i++) begin
      ea = 14'(16380 + i);
      n_tests++; if (en_addrs[i] !== ea) begin n_fail++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, en_addrs[i], ea); end
    end
    n_tests++; if (got_data.size() !== 1) begin n_fail++; $display("FAIL wrap_word_count: got %0d want 1", got_data.size()); end
    if (got_data.size() == 1) begin
      n_tests++; if (got_data[0] !== 8'h0F || got_last[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_word: got %h/last %b want 0f/last 1", got_data[0], got_last[0]); end
    end
  endtask

  task automatic test_partial;
    for (int i = 100; i <= 120; i++) mem[i] = 1'b1;
    run_cmd(14'd100, 15'd11, 1'b0, 40);
    n_tests++; if (busy_low_cyc !== 14) begin n_fail++; $display("FAIL partial_busy_low: got cycle %0d want 14", busy_low_cyc); end
    n_tests++; if (got_data.size() !== 2) begin n_fail++; $display("FAIL partial_word_count: got %0d want 2", got_data.size()); end
    if (got_data.size() == 2) begin
      n_tests++; if (got_data[0] !== 8'hFF || got_last[0] !== 1'b0) begin n_fail++; $display("FAIL partial_word0: got %h/last %b want ff/last 0", got_data[0], got_last[0]); end
      n_tests++; if (got_data[1] !== 8'h07 || got_last[1] !== 1'b1) begin n_fail++; $display("FAIL partial_word1: got %h/last %b want 07/last 1", got_data[1], got_last[1]); end
    end
  endtask

  task automatic test_flow_control;
    logic [7:0] exp;
    for (int i = 1000; i < 1064; i++) mem[i] = 1'(((i * 37) >> 3) ^ (i >> 1) ^ (i % 3 == 0 ? 1 : 0));
    run_cmd(14'd1000, 15'd64, 1'b1, 400);
    n_tests++; if (busy_low_cyc < 0) begin n_fail++; $display("FAIL flow_timeout: busy still high after 400 cycles"); end
    n_tests++; if (got_data.size() !== 8) begin n_fail++; $display("FAIL flow_word_count: got %0d want 8", got_data.size()); end
    for (int w = 0; w < 8 && w < got_data.size(); w++) begin
      for (int b = 0; b < 8; b++) exp[b] = mem[1000 + 8 * w + b];
      n_tests++; if (got_data[w] !== exp || got_last[w] !== (w == 7)) begin n_fail++; $display("FAIL flow_word%0d: got %h/last %b want %h/last %b", w, got_data[w], got_last[w], exp, (w == 7)); end
    end
    n_tests++; if (en_addrs.size() !== 64) begin n_fail++; $display("FAIL flow_read_count: got %0d want 64", en_addrs.size()); end
    n_tests++; if (stall_viol !== 0) begin n_fail++; $display("FAIL flow_stall_rule: got %0d violations want 0", stall_viol); end
    n_tests++; if (hold_viol !== 0) begin n_fail++; $display("FAIL flow_hold_stable: got %0d violations want 0", hold_viol); end
    n_tests++; if (stall_events == 0) begin n_fail++; $display("FAIL flow_stall_seen: got 0 stalled cycles want >0"); end
  endtask

  task automatic test_len_zero_one;
    run_cmd(14'd42, 15'd0, 1'b0, 10);
    n_tests++; if (ready_c1 !== 1'b1) begin n_fail++; $display("FAIL len0_start_ready: got %b want 1", ready_c1); end
    n_tests++; if (busy_low_cyc !== 1) begin n_fail++; $display("FAIL len0_busy: got cycle %0d want 1", busy_low_cyc); end
    n_tests++; if (first_en_cyc !== -1 || first_valid_cyc !== -1) begin n_fail++; $display("FAIL len0_activity: got en %0d valid %0d want -1 -1", first_en_cyc, first_valid_cyc); end
    mem[500] = 1'b1;
    mem[501] = 1'b1;
    run_cmd(14'd500, 15'd1, 1'b0, 20);
    n_tests++; if (got_data.size() !== 1) begin n_fail++; $display("FAIL len1_word_count: got %0d want 1", got_data.size()); end
    if (got_data.size() == 1) begin
      n_tests++; if (got_data[0] !== 8'h01 || got_last[0] !== 1'b1) begin n_fail++; $display("FAIL len1_word: got %h/last %b want 01/last 1", got_data[0], got_last[0]); end
    end
    n_tests++; if (last_valid_cyc !== 3) begin n_fail++; $display("FAIL len1_last_valid: got cycle %0d want 3", last_valid_cyc); end
  endtask

  task automatic test_reset_mid;
    logic pat [0:7] = '{0,1,0,1,1,0,1,0};
    for (int i = 300; i < 332; i++) mem[i] = 1'b1;
    for (int i = 0; i < 8; i++) mem[200 + i] = pat[i];
    @(negedge clk);
    bus.start_valid = 1'b1; bus.start_addr = 14'd300; bus.start_len = 15'd32; bus.out_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    test_reset();
    run_cmd(14'd200, 15'd8, 1'b0, 40);
    n_tests++; if (got_data.size() !== 1) begin n_fail++; $display("FAIL rstmid_word_count: got %0d want 1", got_data.size()); end
    if (got_data.size() == 1) begin
      n_tests++; if (got_data[0] !== 8'h5A || got_last[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_word: got %h/last %b want 5a/last 1", got_data[0], got_last[0]); end
    end
    n_tests++; if (first_valid_cyc !== 10) begin n_fail++; $display("FAIL rstmid_first_valid: got cycle %0d want 10", first_valid_cyc); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 1'b0;
    reset_n = 1'b0;
    bus.start_valid = 1'b0;
    bus.start_addr  = '0;
    bus.start_len   = '0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_partial();
    test_flow_control();
    test_len_zero_one();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ramb16_s1_bit_reader.md
# ramb16_s1_bit_reader

Read-side engine for a 1-bit × 16K dual-port block RAM (RAMB16_S1_S1-class primitive) whose port A is owned by a bit-serial writer. On a start command it drives port B to fetch a contiguous run of bits, starting at any address and wrapping at the end of the RAM. It packs the bits LSB-first into OUT_BITS-wide words and emits them on a valid/ready stream. It sits between the bit RAM and any Rigel word-stream consumer, and provides flow control, wrap-around and last-word flagging.

## Interface
- OUT_BITS, 8, width of packed output word; legal 2..32
- ADDR_BITS, 14, RAM bit-address width; depth is 2^ADDR_BITS

Ports:
- CLK  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start_valid  in  1  command request
- start_ready  out  1  command accepted when start_valid && start_ready
- start_addr  in  ADDR_BITS  first bit address
- start_len  in  ADDR_BITS+1  number of bits, 0..2^ADDR_BITS
- ram_addr  out  ADDR_BITS  to ADDRB
- ram_en  out  1  to ENB
- ram_we  out  1  to WEB; constant 0
- ram_ssr  out  1  to SSRB; constant 0
- ram_do  in  1  from DOB; valid the cycle after ram_en
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  OUT_BITS  packed word; bit 0 is the earliest bit read
- out_last  out  1  final word of the command; qualified by out_valid
- busy  out  1  high from command accept until the last word is accepted

## Operation
- States: IDLE, READ, FLUSH.
- IDLE:
  - start_ready = 1.
  - On accept, latch addr and len.
  - len = 0 → stay IDLE; no RAM access and no output word.
  - Otherwise → READ; busy = 1.
- READ:
  - Each cycle a read is issued, drive ram_en = 1 with ram_addr = current address, then increment the address modulo 2^ADDR_BITS (16383 → 0) and decrement the remaining count.
  - Capture ram_do one cycle later into accumulator bit position cnt; cnt then increments.
  - When cnt reaches OUT_BITS, or the final bit is captured, move the accumulator into the one-deep output register:
    - unread high bits are zero-padded;
    - out_last = 1 if it holds the final bit;
    - the accumulator clears.
  - Issue-stall rule: do not issue a read when (cnt + read_in_flight) == OUT_BITS and the output register stays occupied this cycle (out_valid && !out_ready). No bit may be dropped or duplicated.
  - When the remaining count reaches 0 → FLUSH.
- FLUSH:
  - Wait for the final word to be captured and accepted (out_valid && out_ready && out_last).
  - Then → IDLE; busy falls and start_ready rises in the next cycle.
- start_valid is ignored while not in IDLE.
- out_data and out_last hold stable while out_valid && !out_ready.
- ram_we and ram_ssr are constant 0; port A is never touched.

## Timing
- Reset (reset_n = 0 at an edge) forces, from the next cycle:
  - state = IDLE, start_ready = 1
  - busy, ram_en, out_valid, out_last = 0
  - out_data = 0, ram_addr = 0
  - accumulator and counters = 0
- Reset mid-command abandons it. A read in flight is discarded.
- Cycle 0 = accept edge. The first ram_en is in cycle 1.
- With out_ready held high, one read is issued per cycle and nothing stalls. Bit k is captured at the end of cycle k+2.
- The first out_valid rises in cycle OUT_BITS+2.
- Sustained throughput is one word per OUT_BITS cycles.
- Command latency, len bits, out_ready always 1: last word valid in cycle len+2; busy low in cycle len+3.
- A full word is never delayed behind a partial one. The output register accepts a new word in the same cycle the old word is consumed.
- A command of exactly OUT_BITS×n bits ends with a full word flagged out_last; no empty trailing word.

## Test plan
- RAM preloaded with bits 0..15 = 1,0,1,1,0,0,0,1,1,1,1,1,0,0,0,0; OUT_BITS=8, start_addr=0, len=16, out_ready=1.
  - Required: out_data 0x8D then 0x0F, the second with out_last.
  - First out_valid in cycle 10; busy low in cycle 19.
- start_addr=16380, len=8, RAM bits 16380..16383 = 1 and 0..3 = 0.
  - Required: ram_addr sequence 16380..16383, 0..3; out_data = 0x0F with out_last.
- len=11, all-ones RAM.
  - Required: 0xFF, then 0x07 with out_last (zero-padded).
- len=64 with out_ready toggling pseudo-randomly, including long low stretches.
  - Required: 8 words match a reference model exactly.
  - No ram_en while the stall rule holds; out_data is stable while stalled.
- len=0, then len=1.
  - Required: len=0 gives no ram_en, no out_valid, and start_ready back high in cycle 1.
  - len=1 gives a single word equal to the bit value in bit 0, with out_last.
- reset_n pulsed low in cycle 5 of a len=32 command.
  - Required: all outputs at their reset values the next cycle.
  - A new len=8 command then produces correct data with no stale bits.
